// File: rtl/axis_bram_pkg.sv
// Shared types and sizing helpers for the stream-to-BRAM packet writer.
package axis_bram_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_DRAIN,
      S_DONE
   } state_t;

   // One extra bit so a full memory's worth of beats is representable.
   localparam int BEAT_CNT_EXTRA_BITS = 1;

   function automatic int beat_cnt_width(input int addr_width);
      return addr_width + BEAT_CNT_EXTRA_BITS;
   endfunction

endpackage

// File: rtl/axis_bram_packet_writer.sv
// AXI4-Stream slave that writes one armed packet into a BRAM write port with
// per-byte enables, end-of-memory stop/wrap handling and a completion report.
module axis_bram_packet_writer
   import axis_bram_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_DEPTH  = 1024,
   parameter int WRAP_MODE  = 0
) (
   input  logic                  axis_clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  t_valid,
   output logic                  t_ready,
   input  logic [DATA_WIDTH-1:0] t_data,
   input  logic [KEEP_WIDTH-1:0] t_keep,
   input  logic                  t_last,
   output logic                  bram_ena,
   output logic [KEEP_WIDTH-1:0] bram_wena,
   output logic [ADDR_WIDTH-1:0] bram_address,
   output logic [DATA_WIDTH-1:0] bram_data,
   output logic                  pkt_done,
   output logic [ADDR_WIDTH:0]   pkt_beats,
   output logic                  overflow,
   output logic                  busy
);

   localparam int CNT_W = beat_cnt_width(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(MEM_DEPTH);

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
   logic [CNT_W-1:0]        beat_cnt_reg;
   logic                    t_ready_reg;
   logic                    bram_ena_reg;
   logic [KEEP_WIDTH-1:0]   bram_wena_reg;
   logic [ADDR_WIDTH-1:0]   bram_address_reg;
   logic [DATA_WIDTH-1:0]   bram_data_reg;
   logic                    pkt_done_reg;
   logic [CNT_W-1:0]        pkt_beats_reg;
   logic                    overflow_reg;

   logic [DATA_WIDTH-1:0]   masked_data;
   logic                    accept;
   logic                    has_bytes;
   logic                    at_end;
   logic                    cnt_sat;
   logic                    base_in_range;
   logic [ADDR_WIDTH-1:0]   wr_ptr_next;
   logic [CNT_W-1:0]        beat_cnt_next;

   generate
      for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
         assign masked_data[8*gi +: 8] = t_keep[gi] ? t_data[8*gi +: 8] : 8'h00;
      end
   endgenerate

   assign accept        = t_valid && t_ready_reg;
   assign has_bytes     = |t_keep;
   assign at_end        = (wr_ptr_reg == LAST_ADDR);
   assign cnt_sat       = (beat_cnt_reg == DEPTH_CNT);
   assign base_in_range = ({1'b0, base_addr} < DEPTH_CNT);
   // Pointer wraps at MEM_DEPTH, which need not be a power of two.
   assign wr_ptr_next   = at_end ? '0 : wr_ptr_reg + ADDR_WIDTH'(1);
   assign beat_cnt_next = cnt_sat ? beat_cnt_reg : beat_cnt_reg + CNT_W'(1);

   always_ff @(posedge axis_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= S_IDLE;
         wr_ptr_reg       <= '0;
         beat_cnt_reg     <= '0;
         t_ready_reg      <= 1'b0;
         bram_ena_reg     <= 1'b0;
         bram_wena_reg    <= '0;
         bram_address_reg <= '0;
         bram_data_reg    <= '0;
         pkt_done_reg     <= 1'b0;
         pkt_beats_reg    <= '0;
         overflow_reg     <= 1'b0;
      end else begin
         bram_ena_reg  <= 1'b0;
         bram_wena_reg <= '0;
         pkt_done_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  wr_ptr_reg    <= base_in_range ? base_addr : '0;
                  beat_cnt_reg  <= '0;
                  overflow_reg  <= 1'b0;
                  pkt_beats_reg <= '0;
                  t_ready_reg   <= 1'b1;
                  state_reg     <= S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  if (has_bytes) begin
                     bram_ena_reg     <= 1'b1;
                     bram_wena_reg    <= t_keep;
                     bram_address_reg <= wr_ptr_reg;
                     bram_data_reg    <= masked_data;
                     wr_ptr_reg       <= wr_ptr_next;
                     beat_cnt_reg     <= beat_cnt_next;
                     if (cnt_sat) begin
                        overflow_reg <= 1'b1;
                     end
                  end
                  if (t_last) begin
                     pkt_beats_reg <= has_bytes ? beat_cnt_next : beat_cnt_reg;
                     pkt_done_reg  <= 1'b1;
                     t_ready_reg   <= 1'b0;
                     state_reg     <= S_DONE;
                  end else if (has_bytes && at_end && (WRAP_MODE == 0)) begin
                     overflow_reg <= 1'b1;
                     state_reg    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (accept && t_last) begin
                  pkt_beats_reg <= beat_cnt_reg;
                  pkt_done_reg  <= 1'b1;
                  t_ready_reg   <= 1'b0;
                  state_reg     <= S_DONE;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               t_ready_reg <= 1'b0;
               state_reg   <= S_IDLE;
            end
         endcase
      end
   end

   assign t_ready      = t_ready_reg;
   assign bram_ena     = bram_ena_reg;
   assign bram_wena    = bram_wena_reg;
   assign bram_address = bram_address_reg;
   assign bram_data    = bram_data_reg;
   assign pkt_done     = pkt_done_reg;
   assign pkt_beats    = pkt_beats_reg;
   assign overflow     = overflow_reg;
   assign busy         = (state_reg != S_IDLE);

endmodule

// File: doc/axis_bram_packet_writer.md
# axis_bram_packet_writer

Parametrised AXI4-Stream slave that writes one packet per arm command into a BRAM write port, starting at a programmable base address. Second-generation stream-to-BRAM writer: per-byte write enables from `t_keep`, selectable wrap/stop mode at end of memory, overflow detection with drain-to-`t_last`, and a per-packet completion report. Sits between the PCIe completer-request stream and the packet BRAM.

## Interface
Parameters:
- `DATA_WIDTH`, 512, stream and BRAM data width in bits; multiple of 8.
- `KEEP_WIDTH`, `DATA_WIDTH/8`, byte-lane count.
- `ADDR_WIDTH`, 10, BRAM address width.
- `MEM_DEPTH`, 1024, BRAM words; must satisfy MEM_DEPTH ≤ 2^ADDR_WIDTH.
- `WRAP_MODE`, 0, 0 = stop at end of memory, 1 = wrap to address 0.

Ports:
- `axis_clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  arm pulse; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first write address; latched on accepted `start`.
- `t_valid`  in  1  stream valid.
- `t_ready`  out  1  stream ready; registered.
- `t_data`  in  DATA_WIDTH  stream data.
- `t_keep`  in  KEEP_WIDTH  byte valid; bit i qualifies `t_data[8i+7:8i]`.
- `t_last`  in  1  final beat of packet.
- `bram_ena`  out  1  BRAM port enable.
- `bram_wena`  out  KEEP_WIDTH  per-byte write enable.
- `bram_address`  out  ADDR_WIDTH  write address.
- `bram_data`  out  DATA_WIDTH  write data; unkept bytes driven 0.
- `pkt_done`  out  1  one-cycle completion pulse.
- `pkt_beats`  out  ADDR_WIDTH+1  beats written for the last packet; held until next accepted `start`.
- `overflow`  out  1  sticky; cleared on accepted `start`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, DATA, DRAIN, DONE.
- IDLE: `t_ready`=0. `start`=1 → latch `base_addr` into `wr_ptr`; clear `beat_cnt`, `overflow`, `pkt_beats`; → DATA. If `base_addr` ≥ MEM_DEPTH, `wr_ptr`=0.
- DATA: `t_ready`=1. Accepted beat (`t_valid && t_ready`) with nonzero `t_keep` → write issued next cycle at `wr_ptr`; `wr_ptr` += 1; `beat_cnt` += 1.
- Beat with `t_keep`=0: accepted, not written, not counted, `wr_ptr` unchanged; its `t_last` is still honoured.
- `t_last` accepted → DONE.
- Pointer at MEM_DEPTH-1 written without `t_last`:
  - WRAP_MODE=1: `wr_ptr` → 0 and stay in DATA. `overflow` sets when `beat_cnt` would exceed MEM_DEPTH; `beat_cnt` saturates at MEM_DEPTH.
  - WRAP_MODE=0: set `overflow`; → DRAIN.
- DRAIN: `t_ready`=1; beats are accepted and discarded with no BRAM activity; `t_last` → DONE.
- DONE (one cycle): `pkt_done`=1, `pkt_beats`=`beat_cnt`, `t_ready`=0; → IDLE.
- `start` outside IDLE is ignored.
- Widths: `beat_cnt` is ADDR_WIDTH+1 bits so that MEM_DEPTH is representable. Pointer increment is modulo MEM_DEPTH, not 2^ADDR_WIDTH.

## Timing
- Reset values (`reset_n`=0, immediate): state IDLE; all outputs 0, including `bram_data`, `pkt_beats` and `overflow`. A write in flight is dropped.
- `start` high at edge N → `t_ready`=1 from N+1.
- Write latency: a beat accepted at edge N drives `bram_ena`=1, `bram_wena`=`t_keep`, address and data during cycle N..N+1. The BRAM captures it at edge N+1.
- Back-to-back beats produce one write per cycle with no bubbles.
- `t_last` accepted at edge N → `t_ready`=0 and `pkt_done`=1 in the same cycle as the final write. Next `start` is accepted at N+2 at the earliest.
- In all other cycles `bram_ena`=0 and `bram_wena`=0.
- `t_valid` low inside DATA stalls without penalty; state is held.

## Structure
- Package `axis_bram_pkg`: state enum (IDLE, DATA, DRAIN, DONE) and a constant for the `beat_cnt` width (ADDR_WIDTH+1).
- Single module. The byte-masking loop (zero unkept lanes) is inline; no sub-module.

## Test plan
Bench config: DATA_WIDTH=32, ADDR_WIDTH=3, MEM_DEPTH=8.
- Basic packet: start with base 2, send 3 full-keep beats (A, B, C; `t_last` on C) → writes A@2, B@3, C@4 with `bram_wena`=4'hF; `pkt_done` once; `pkt_beats`=3; `overflow`=0.
- Partial keep: a single beat with data 0x11223344, keep 4'b0101 and `t_last` → `bram_data`=0x00220044, `bram_wena`=4'b0101. A following keep=0 beat in a second packet is not written and not counted.
- Stop mode: base 6, 4 beats → writes @6 and @7; `overflow`=1; beats 3–4 discarded; `pkt_done` with `pkt_beats`=2.
- Wrap mode (WRAP_MODE=1): base 6, 4 beats → writes @6, @7, @0, @1; `overflow`=0; `pkt_beats`=4. With base 0 and 9 beats → `overflow`=1 and `pkt_beats`=8.
- Backpressure-free stall: `t_valid` toggling 1-0-1 → no write in the gap and addresses stay contiguous. `start` pulsed mid-packet is ignored.
- Reset mid-packet: assert `reset_n`=0 after 2 beats → all outputs 0 immediately. After release, a new `start` writes from the new base with `pkt_beats` counting from 0.
